// File: rtl/mux16_scan_seq_if.sv
// Select/sample/frame bundle between the scan sequencer (master) and the
// mux plus frame consumer (slave).
interface mux16_scan_seq_if;
  logic        START;
  logic        CONT;
  logic        SD1, SD2, SD3, SD4;
  logic        ZIN;
  logic [15:0] FRAME;
  logic        FVALID;
  logic        FREADY;
  logic        BUSY;
  logic        XERR;

  modport master (
    input  START, CONT, ZIN, FREADY,
    output SD1, SD2, SD3, SD4, FRAME, FVALID, BUSY, XERR
  );

  modport slave (
    output START, CONT, ZIN, FREADY,
    input  SD1, SD2, SD3, SD4, FRAME, FVALID, BUSY, XERR
  );
endinterface

// File: rtl/mux16_scan_seq.sv
// Scan sequencer for a 16:1 select mux: walks all channels, samples ZIN after a
// settle interval and publishes a 16-bit frame. Define MUX16_SCAN_XCHK_EN for X/Z sample flagging.
module mux16_scan_seq #(
  parameter int SETTLE = 1
) (
  input  logic              CK,
  input  logic              RN,
  mux16_scan_seq_if.master  bus
);

  localparam logic [3:0] SETTLE_W = SETTLE[3:0];

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_HOLD} state_e;

  state_e      state_q, state_d;
  logic [3:0]  sel_q, sel_d;
  logic [3:0]  wait_q, wait_d;
  logic [15:0] cap_q, cap_d;
  logic [15:0] frame_q, frame_d;
  logic        fvalid_q, fvalid_d;

`ifdef MUX16_SCAN_XCHK_EN
  logic xflag_q, xflag_d;
  logic xerr_q, xerr_d;
  logic zin_bad;
  assign zin_bad = (bus.ZIN === 1'bx) || (bus.ZIN === 1'bz);
`endif

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q  <= S_IDLE;
      sel_q    <= '0;
      wait_q   <= '0;
      cap_q    <= '0;
      frame_q  <= '0;
      fvalid_q <= 1'b0;
`ifdef MUX16_SCAN_XCHK_EN
      xflag_q  <= 1'b0;
      xerr_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      wait_q   <= wait_d;
      cap_q    <= cap_d;
      frame_q  <= frame_d;
      fvalid_q <= fvalid_d;
`ifdef MUX16_SCAN_XCHK_EN
      xflag_q  <= xflag_d;
      xerr_q   <= xerr_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    wait_d   = wait_q;
    cap_d    = cap_q;
    frame_d  = frame_q;
    fvalid_d = fvalid_q;
`ifdef MUX16_SCAN_XCHK_EN
    xflag_d  = xflag_q;
    xerr_d   = xerr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.START) begin
          sel_d   = '0;
          wait_d  = SETTLE_W;
          state_d = S_SCAN;
`ifdef MUX16_SCAN_XCHK_EN
          xflag_d = 1'b0;
`endif
        end
      end
      S_SCAN: begin
        if (wait_q != 4'd0) begin
          wait_d = wait_q - 4'd1;
        end else begin
          cap_d[sel_q] = bus.ZIN;
`ifdef MUX16_SCAN_XCHK_EN
          xflag_d = xflag_q | zin_bad;
`endif
          if (sel_q != 4'd15) begin
            sel_d  = sel_q + 4'd1;
            wait_d = SETTLE_W;
          end else begin
            // Channel 15 goes straight into the frame on the same edge it is sampled.
            frame_d     = cap_q;
            frame_d[15] = bus.ZIN;
            fvalid_d    = 1'b1;
            sel_d       = '0;
            state_d     = S_HOLD;
`ifdef MUX16_SCAN_XCHK_EN
            xerr_d = xflag_q | zin_bad;
`endif
          end
        end
      end
      S_HOLD: begin
        if (bus.FREADY) begin
          fvalid_d = 1'b0;
          if (bus.CONT || bus.START) begin
            sel_d   = '0;
            wait_d  = SETTLE_W;
            state_d = S_SCAN;
`ifdef MUX16_SCAN_XCHK_EN
            xflag_d = 1'b0;
`endif
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign {bus.SD4, bus.SD3, bus.SD2, bus.SD1} = sel_q;
  assign bus.FRAME  = frame_q;
  assign bus.FVALID = fvalid_q;
  assign bus.BUSY   = (state_q == S_SCAN);
`ifdef MUX16_SCAN_XCHK_EN
  assign bus.XERR   = xerr_q;
`else
  assign bus.XERR   = 1'b0;
`endif

endmodule

// File: tb/tb_mux16_scan_seq.sv
// Directed bench: three sequencers (SETTLE=0,1,2) each driven by a behavioural
// 16:1 mux model; expected values are hand-computed from the scan timing.
module tb_mux16_scan_seq;

`ifdef MUX16_SCAN_XCHK_EN
  localparam bit XCHK = 1'b1;
`else
  localparam bit XCHK = 1'b0;
`endif

  logic CK = 1'b0;
  logic RN = 1'b0;
  always #5 CK = ~CK;

  int checks = 0;
  int errors = 0;

  mux16_scan_seq_if b0 ();
  mux16_scan_seq_if b1 ();
  mux16_scan_seq_if b2 ();

  mux16_scan_seq #(.SETTLE(0)) u0 (.CK(CK), .RN(RN), .bus(b0.master));
  mux16_scan_seq #(.SETTLE(1)) u1 (.CK(CK), .RN(RN), .bus(b1.master));
  mux16_scan_seq #(.SETTLE(2)) u2 (.CK(CK), .RN(RN), .bus(b2.master));

  logic [15:0] pat0, pat1, pat2;
  logic        xinj;
  logic [3:0]  sel0, sel1, sel2;

  assign sel0 = {b0.SD4, b0.SD3, b0.SD2, b0.SD1};
  assign sel1 = {b1.SD4, b1.SD3, b1.SD2, b1.SD1};
  assign sel2 = {b2.SD4, b2.SD3, b2.SD2, b2.SD1};

  assign b0.ZIN = pat0[sel0];
  assign b1.ZIN = (xinj && sel1 == 4'd7) ? 1'bx : pat1[sel1];
  assign b2.ZIN = pat2[sel2];

  task automatic test_reset();
    #12;
    checks++;
    if (b1.FVALID !== 1'b0 || b1.BUSY !== 1'b0 || sel1 !== 4'd0 || b1.FRAME !== 16'h0 || b1.XERR !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: fvalid=%b busy=%b sel=%0d frame=%h xerr=%b, want all zero",
               b1.FVALID, b1.BUSY, sel1, b1.FRAME, b1.XERR);
    end
    @(negedge CK);
    RN = 1'b1;
    @(negedge CK);
  endtask

  task automatic test_single_frame();
    pat1 = 16'hA5C3;
    b1.START = 1'b1;
    @(negedge CK);
    b1.START = 1'b0;
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (sel1 !== 4'(i / 2) || b1.FVALID !== 1'b0 || b1.BUSY !== 1'b1) begin
        errors++;
        $display("FAIL single_scan_cyc%0d: sel=%0d fvalid=%b busy=%b, want sel=%0d fvalid=0 busy=1",
                 i, sel1, b1.FVALID, b1.BUSY, i / 2);
      end
      @(negedge CK);
    end
    checks++;
    if (b1.FVALID !== 1'b1 || b1.FRAME !== 16'hA5C3 || b1.BUSY !== 1'b0 || sel1 !== 4'd0) begin
      errors++;
      $display("FAIL single_publish: fvalid=%b frame=%h busy=%b sel=%0d, want 1 a5c3 0 0",
               b1.FVALID, b1.FRAME, b1.BUSY, sel1);
    end
    b1.FREADY = 1'b1;
    @(negedge CK);
    b1.FREADY = 1'b0;
    checks++;
    if (b1.FVALID !== 1'b0 || b1.BUSY !== 1'b0 || b1.FRAME !== 16'hA5C3) begin
      errors++;
      $display("FAIL single_accept: fvalid=%b busy=%b frame=%h, want 0 0 a5c3", b1.FVALID, b1.BUSY, b1.FRAME);
    end
  endtask

  task automatic test_reset_mid_scan();
    int seen;
    b1.START = 1'b1;
    @(negedge CK);
    b1.START = 1'b0;
    repeat (9) @(negedge CK);
    #2 RN = 1'b0;
    #1;
    checks++;
    if (b1.FVALID !== 1'b0 || b1.BUSY !== 1'b0 || sel1 !== 4'd0 || b1.FRAME !== 16'h0) begin
      errors++;
      $display("FAIL reset_mid_scan: fvalid=%b busy=%b sel=%0d frame=%h, want 0 0 0 0000",
               b1.FVALID, b1.BUSY, sel1, b1.FRAME);
    end
    @(negedge CK);
    RN = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CK);
      if (b1.FVALID !== 1'b0 || b1.BUSY !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_no_publish: active cycles=%0d, want 0", seen);
    end
  endtask

  task automatic test_backpressure();
    int n;
    int bad;
    pat0 = 16'h1234;
    b0.START = 1'b1;
    n = 0;
    while (n < 60) begin
      @(negedge CK);
      n++;
      b0.START = 1'b0;
      if (b0.FVALID === 1'b1) break;
    end
    checks++;
    if (n != 17 || b0.FRAME !== 16'h1234) begin
      errors++;
      $display("FAIL bp_publish: cycles=%0d frame=%h, want 17 1234", n, b0.FRAME);
    end
    bad = 0;
    pat0 = 16'hFFFF;
    for (int i = 0; i < 20; i++) begin
      @(negedge CK);
      if (b0.FVALID !== 1'b1 || b0.FRAME !== 16'h1234 || b0.BUSY !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold: unstable cycles=%0d, want 0", bad);
    end
    b0.FREADY = 1'b1;
    @(negedge CK);
    b0.FREADY = 1'b0;
    checks++;
    if (b0.FVALID !== 1'b0 || b0.BUSY !== 1'b0) begin
      errors++;
      $display("FAIL bp_accept: fvalid=%b busy=%b, want 0 0", b0.FVALID, b0.BUSY);
    end
    repeat (3) @(negedge CK);
    checks++;
    if (b0.BUSY !== 1'b0 || b0.FVALID !== 1'b0 || b0.FRAME !== 16'h1234) begin
      errors++;
      $display("FAIL bp_idle: busy=%b fvalid=%b frame=%h, want 0 0 1234", b0.BUSY, b0.FVALID, b0.FRAME);
    end
  endtask

  task automatic test_continuous();
    int n;
    pat0 = 16'h5A3C;
    b0.CONT = 1'b1;
    b0.FREADY = 1'b1;
    b0.START = 1'b1;
    n = 0;
    while (n < 60) begin
      @(negedge CK);
      n++;
      b0.START = 1'b0;
      if (b0.FVALID === 1'b1) break;
    end
    checks++;
    if (n != 17 || b0.FRAME !== 16'h5A3C) begin
      errors++;
      $display("FAIL cont_frame1: cycles=%0d frame=%h, want 17 5a3c", n, b0.FRAME);
    end
    pat0 = 16'hFFFF;
    n = 0;
    while (n < 60) begin
      @(negedge CK);
      n++;
      if (b0.FVALID === 1'b1) break;
    end
    checks++;
    if (n != 17 || b0.FRAME !== 16'hFFFF) begin
      errors++;
      $display("FAIL cont_frame2: cycles=%0d frame=%h, want 17 ffff", n, b0.FRAME);
    end
    b0.CONT = 1'b0;
    @(negedge CK);
    b0.FREADY = 1'b0;
    @(negedge CK);
    checks++;
    if (b0.BUSY !== 1'b0 || b0.FVALID !== 1'b0) begin
      errors++;
      $display("FAIL cont_stop: busy=%b fvalid=%b, want 0 0", b0.BUSY, b0.FVALID);
    end
  endtask

  task automatic test_start_ignored();
    int n;
    pat2 = 16'h0F0F;
    b2.START = 1'b1;
    n = 0;
    while (n < 100) begin
      @(negedge CK);
      n++;
      if (n == 7) begin
        checks++;
        if (sel2 !== 4'd2) begin
          errors++;
          $display("FAIL start_ign_sel: sel=%0d at cycle 7, want 2", sel2);
        end
      end
      if (b2.FVALID === 1'b1) break;
    end
    b2.START = 1'b0;
    checks++;
    if (n != 49 || b2.FRAME !== 16'h0F0F) begin
      errors++;
      $display("FAIL start_ign_publish: cycles=%0d frame=%h, want 49 0f0f", n, b2.FRAME);
    end
    b2.FREADY = 1'b1;
    @(negedge CK);
    b2.FREADY = 1'b0;
    @(negedge CK);
    checks++;
    if (b2.BUSY !== 1'b0 || b2.FVALID !== 1'b0) begin
      errors++;
      $display("FAIL start_ign_idle: busy=%b fvalid=%b, want 0 0", b2.BUSY, b2.FVALID);
    end
  endtask

  task automatic test_xchk();
    int n;
    pat1 = 16'hFFFF;
    xinj = 1'b1;
    b1.START = 1'b1;
    n = 0;
    while (n < 80) begin
      @(negedge CK);
      n++;
      b1.START = 1'b0;
      if (b1.FVALID === 1'b1) break;
    end
    checks++;
    if (n != 33 || b1.XERR !== XCHK) begin
      errors++;
      $display("FAIL xchk_dirty: cycles=%0d xerr=%b, want 33 %b", n, b1.XERR, XCHK);
    end
    xinj = 1'b0;
    b1.FREADY = 1'b1;
    b1.START = 1'b1;
    @(negedge CK);
    b1.FREADY = 1'b0;
    b1.START = 1'b0;
    n = 1;
    while (n < 80) begin
      if (b1.FVALID === 1'b1) break;
      @(negedge CK);
      n++;
    end
    checks++;
    if (n != 33 || b1.XERR !== 1'b0 || b1.FRAME !== 16'hFFFF) begin
      errors++;
      $display("FAIL xchk_clean: cycles=%0d xerr=%b frame=%h, want 33 0 ffff", n, b1.XERR, b1.FRAME);
    end
  endtask

  initial begin
    pat0 = '0; pat1 = '0; pat2 = '0; xinj = 1'b0;
    b0.START = 0; b0.CONT = 0; b0.FREADY = 0;
    b1.START = 0; b1.CONT = 0; b1.FREADY = 0;
    b2.START = 0; b2.CONT = 0; b2.FREADY = 0;
    test_reset();
    test_single_frame();
    test_reset_mid_scan();
    test_backpressure();
    test_continuous();
    test_start_ignored();
    test_xchk();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
